rv32i_r_type_encoder: RTL
=========================

# rv32i_r_type_encoder

Assembles RV32I R-type instruction words from operation and register fields, the encode direction of the instruction-field decode path that feeds the ALU. Accepted requests are encoded, buffered in a small FIFO, and emitted with an incrementing word address. The output stream loads program images into instruction memory and drives decoder/ALU benches. Unsupported operation codes are consumed and flagged; they are never emitted.

## Interface
- ADDR_WIDTH, 8, width of output word-address counter
- DEPTH, 4, FIFO entries; power of two, at least 2
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  when low, no new requests are accepted; output side keeps draining
- in_valid  in  1  request valid
- in_ready  out  1  request can be accepted
- op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 illegal
- rd, rs1, rs2  in  5 each  register indices
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_instruction  out  32  encoded word
- out_address  out  ADDR_WIDTH  word address tagged to out_instruction
- illegal_op  out  1  one-cycle pulse on an accepted illegal op
- illegal_count  out  8  saturating count of illegal ops
- level  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Input handshake: in_ready = enable && (level != DEPTH). A transfer occurs on a rising edge with in_valid && in_ready.
- Encoding: out_instruction = {funct7, rs2, rs1, funct3, rd, 7'b0110011}. funct7 = 7'b0100000 for SUB and SRA, otherwise 0.
- funct3 values: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- Encoding is done before the FIFO write; FIFO entries hold the finished 32-bit words.
- Illegal op (10-15) on a transfer:
  - nothing is written to the FIFO;
  - illegal_op pulses high for the following cycle;
  - illegal_count increments and saturates at 255.
- Output handshake: a pop occurs on a rising edge with out_valid && out_ready.
  - out_valid = (level != 0).
  - out_instruction shows the FIFO head.
  - out_address holds a counter that increments by 1 on every pop and wraps from 2^ADDR_WIDTH-1 to 0.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and data order is preserved.
- Full: in_ready is low even if a pop happens in the same cycle. There is no pop-to-push bypass.
- Empty: out_valid is low, and out_instruction holds its last value (don't-care).
- Deasserting enable does not stall the output side and does not clear stored data.

## Timing
- Reset (asynchronous, effective immediately):
  - level = 0, out_valid = 0;
  - out_address = 0, illegal_count = 0, illegal_op = 0;
  - FIFO pointers = 0; in_ready = enable.
- Reset mid-operation discards all buffered words. The address counter restarts at 0.
- Latency: a request accepted at edge N into an empty FIFO gives out_valid = 1 after edge N (visible in cycle N+1). There is no combinational path from in_valid to out_valid.
- out_ready to in_ready is combinational only through level, i.e. a registered value. There is no same-cycle combinational path.
- Throughput: 1 word per cycle sustained when out_ready is held high.
- illegal_op is registered: high for exactly one cycle after the accepting edge.

## Test plan
- Basic encodes:
  - ADD rd=3, rs1=1, rs2=2 -> 0x002081B3 at out_address 0.
  - SUB rd=5, rs1=6, rs2=7 -> 0x407302B3 at out_address 1.
  - SRA rd=10, rs1=11, rs2=12 -> 0x40C5D533 at out_address 2.
- Backpressure and fill: out_ready=0 with 5 back-to-back ops and DEPTH=4.
  - Expect 4 accepted, in_ready=0 and level=4 afterwards.
  - Raising out_ready drains the words in order, and the fifth op is accepted the cycle after the first pop.
- Illegal op: op=12 between two legal ops.
  - Expect a one-cycle illegal_op pulse and illegal_count=1.
  - Only two words are emitted, with consecutive addresses.
  - 300 illegal ops -> illegal_count=255.
- Address wrap: ADDR_WIDTH=2, 6 pops -> addresses 0,1,2,3,0,1.
- Enable and reset:
  - enable=0 with in_valid=1 -> no accept, while buffered words still drain.
  - reset_n pulsed low with level=3 -> out_valid=0, level=0 and out_address=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv32i_r_type_encoder.sv
// RV32I R-type instruction encoder: turns op/register fields into finished words,
// buffers them in a small FIFO and emits each with an incrementing word address.
module rv32i_r_type_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              op,
  input  logic [4:0]              rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instruction,
  output logic [ADDR_WIDTH-1:0]   out_address,
  output logic                    illegal_op,
  output logic [7:0]              illegal_count,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  logic [31:0]           mem_q [DEPTH];
  logic [PW-1:0]         wrPtr_q;
  logic [PW-1:0]         rdPtr_q;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  illegal_q;
  logic [7:0]            illCount_q;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        opLegal;
  logic [31:0] encodedWord;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    funct3  = 3'b000;
    funct7  = 7'b0000000;
    opLegal = 1'b1;
    case (op)
      4'd0: funct3 = 3'b000;
      4'd1: begin
        funct3 = 3'b000;
        funct7 = 7'b0100000;
      end
      4'd2: funct3 = 3'b001;
      4'd3: funct3 = 3'b010;
      4'd4: funct3 = 3'b011;
      4'd5: funct3 = 3'b100;
      4'd6: funct3 = 3'b101;
      4'd7: begin
        funct3 = 3'b101;
        funct7 = 7'b0100000;
      end
      4'd8: funct3 = 3'b110;
      4'd9: funct3 = 3'b111;
      default: opLegal = 1'b0;
    endcase
    encodedWord = {funct7, rs2, rs1, funct3, rd, OPCODE_OP};
  end

  // in_ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready        = enable && (level_q != FULL_LEVEL);
  assign out_valid       = (level_q != '0);
  assign accept          = in_valid && in_ready;
  assign push            = accept && opLegal;
  assign pop             = out_valid && out_ready;
  assign out_instruction = mem_q[rdPtr_q];
  assign out_address     = addr_q;
  assign illegal_op      = illegal_q;
  assign illegal_count   = illCount_q;
  assign level           = level_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      addr_q     <= '0;
      illegal_q  <= 1'b0;
      illCount_q <= 8'd0;
    end else begin
      level_q   <= level_d;
      illegal_q <= accept && !opLegal;
      if (push) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
        addr_q  <= addr_q + ADDR_WIDTH'(1);
      end
      if (accept && !opLegal && (illCount_q != 8'hFF)) begin
        illCount_q <= illCount_q + 8'd1;
      end
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wrPtr_q] <= encodedWord;
    end
  end

endmodule
